// File: rtl/pll_lock_monitor_if.sv
// PLL lock monitor signal bundle.
// The monitor side (master) consumes the PLL lock status and the restart
// request, and drives the PLL reset, the downstream reset/clock-good
// indications and the status counters. The slave side is the surrounding
// system (PLL, reset distribution, status readers).
interface pll_lock_monitor_if;
  logic       locked;
  logic       force_reset;
  logic       dcm_reset;
  logic       sys_reset_n;
  logic       clk_ok;
  logic [1:0] state;
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;

  modport master (
    input  locked,
    input  force_reset,
    output dcm_reset,
    output sys_reset_n,
    output clk_ok,
    output state,
    output relock_cnt,
    output timeout_cnt
  );

  modport slave (
    output locked,
    output force_reset,
    input  dcm_reset,
    input  sys_reset_n,
    input  clk_ok,
    input  state,
    input  relock_cnt,
    input  timeout_cnt
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor / reset sequencer.
// Pulses the PLL reset, waits for lock (with retry on timeout), requires a
// window of continuous lock before releasing the output-domain reset, and
// restarts the whole sequence whenever lock is lost or a restart is forced.
// All outputs come straight from flops; the asynchronous lock input is only
// used after a two-flop synchronizer.
module pll_lock_monitor #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 4096,
  parameter int STABLE_CYCLES    = 256
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  pll_lock_monitor_if.master    bus
);

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Terminal counts: the counter starts at 0 on entry, so the last cycle of
  // an N-cycle phase is the one where the counter reads N-1.
  localparam logic [15:0] RST_LAST     = 16'(RST_PULSE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);

  // Saturating 8-bit increment for the event counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

  logic        sync_meta_r;
  logic        locked_s;
  state_t      state_r;
  logic [15:0] cnt_r;
  logic        dcm_reset_r;
  logic        sys_reset_n_r;
  logic        clk_ok_r;
  logic [7:0]  relock_cnt_r;
  logic [7:0]  timeout_cnt_r;

  // Two-flop synchronizer bringing the PLL lock status into clk_in.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_r <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      sync_meta_r <= bus.locked;
      locked_s    <= sync_meta_r;
    end
  end

  // Sequencer FSM with its shared cycle counter, registered outputs and
  // event counters. A forced restart overrides every other transition and
  // never counts as a lock loss or timeout.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_RST;
      cnt_r         <= 16'd0;
      dcm_reset_r   <= 1'b1;
      sys_reset_n_r <= 1'b0;
      clk_ok_r      <= 1'b0;
      relock_cnt_r  <= 8'd0;
      timeout_cnt_r <= 8'd0;
    end else if (bus.force_reset) begin
      state_r       <= ST_RST;
      cnt_r         <= 16'd0;
      dcm_reset_r   <= 1'b1;
      sys_reset_n_r <= 1'b0;
      clk_ok_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_RST: begin
          if (cnt_r == RST_LAST) begin
            state_r     <= ST_WAIT_LOCK;
            cnt_r       <= 16'd0;
            dcm_reset_r <= 1'b0;
          end else begin
            cnt_r       <= cnt_r + 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_r <= ST_STABLE;
            cnt_r   <= 16'd0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r       <= ST_RST;
            cnt_r         <= 16'd0;
            dcm_reset_r   <= 1'b1;
            timeout_cnt_r <= sat_inc(timeout_cnt_r);
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_r      <= ST_RST;
            cnt_r        <= 16'd0;
            dcm_reset_r  <= 1'b1;
            relock_cnt_r <= sat_inc(relock_cnt_r);
          end else if (cnt_r == STABLE_LAST) begin
            state_r       <= ST_RUN;
            cnt_r         <= 16'd0;
            sys_reset_n_r <= 1'b1;
            clk_ok_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_r       <= ST_RST;
            cnt_r         <= 16'd0;
            dcm_reset_r   <= 1'b1;
            sys_reset_n_r <= 1'b0;
            clk_ok_r      <= 1'b0;
            relock_cnt_r  <= sat_inc(relock_cnt_r);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r       <= ST_RST;
          cnt_r         <= 16'd0;
          dcm_reset_r   <= 1'b1;
          sys_reset_n_r <= 1'b0;
          clk_ok_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state       = state_r;
  assign bus.dcm_reset   = dcm_reset_r;
  assign bus.sys_reset_n = sys_reset_n_r;
  assign bus.clk_ok      = clk_ok_r;
  assign bus.relock_cnt  = relock_cnt_r;
  assign bus.timeout_cnt = timeout_cnt_r;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor (RST_PULSE_CYCLES=4,
// LOCK_TIMEOUT=32, STABLE_CYCLES=8). A phase/elapsed-time reference model
// predicts every output each cycle; directed scenarios add explicit timing
// checks and randomized lock/force traffic exercises the rest.
module tb_pll_lock_monitor;
  localparam int P = 4;
  localparam int T = 32;
  localparam int S = 8;

  logic clk_in;
  logic reset_n;
  pll_lock_monitor_if bus ();

  pll_lock_monitor #(
    .RST_PULSE_CYCLES(P),
    .LOCK_TIMEOUT    (T),
    .STABLE_CYCLES   (S)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0=RST 1=WAIT_LOCK 2=STABLE 3=RUN, time in phase,
  // event counts, and the lock samples still travelling through the
  // two-cycle synchronizer.
  int m_phase;
  int m_elapsed;
  int m_relock;
  int m_timeout;
  bit hist[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_relock  = 0;
    m_timeout = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit lk, input bit fr);
    bit ls;
    ls = hist.pop_front();
    hist.push_back(lk);
    if (fr) begin
      m_phase   = 0;
      m_elapsed = 0;
    end else begin
      case (m_phase)
        0: begin
          m_elapsed++;
          if (m_elapsed == P) begin m_phase = 1; m_elapsed = 0; end
        end
        1: begin
          if (ls) begin
            m_phase = 2; m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == T) begin
              m_phase = 0; m_elapsed = 0;
              if (m_timeout < 255) m_timeout++;
            end
          end
        end
        2: begin
          if (!ls) begin
            m_phase = 0; m_elapsed = 0;
            if (m_relock < 255) m_relock++;
          end else begin
            m_elapsed++;
            if (m_elapsed == S) begin m_phase = 3; m_elapsed = 0; end
          end
        end
        3: begin
          if (!ls) begin
            m_phase = 0; m_elapsed = 0;
            if (m_relock < 255) m_relock++;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic check_all();
    check_eq("state",       int'(bus.state),       m_phase);
    check_eq("dcm_reset",   int'(bus.dcm_reset),   (m_phase == 0) ? 1 : 0);
    check_eq("sys_reset_n", int'(bus.sys_reset_n), (m_phase == 3) ? 1 : 0);
    check_eq("clk_ok",      int'(bus.clk_ok),      (m_phase == 3) ? 1 : 0);
    check_eq("relock_cnt",  int'(bus.relock_cnt),  m_relock);
    check_eq("timeout_cnt", int'(bus.timeout_cnt), m_timeout);
  endtask

  // One clock cycle: drive inputs, advance model at the edge, check at negedge.
  task automatic cycle(input bit lk, input bit fr);
    bus.locked      = lk;
    bus.force_reset = fr;
    @(posedge clk_in);
    model_step(lk, fr);
    @(negedge clk_in);
    check_all();
  endtask

  task automatic wait_model(input int ph, input int el, input bit lk,
                            input int max, input string tag);
    int n;
    n = 0;
    while (!(m_phase == ph && m_elapsed == el) && n < max) begin
      cycle(lk, 1'b0);
      n++;
    end
    if (!(m_phase == ph && m_elapsed == el)) check_eq(tag, m_phase, ph);
  endtask

  task automatic wait_run(input int max, input string tag);
    int n;
    n = 0;
    while (!bus.clk_ok && n < max) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq(tag, int'(bus.clk_ok), 1);
  endtask

  initial begin
    int n;
    bit lkv;
    reset_n         = 1'b0;
    bus.locked      = 1'b0;
    bus.force_reset = 1'b0;
    model_reset();

    // Reset state while reset_n is held low.
    repeat (2) @(negedge clk_in);
    check_all();
    reset_n = 1'b1;

    // Power-up: 4-cycle PLL reset, then lock 10 cycles after release.
    n = 0;
    do begin
      cycle(1'b0, 1'b0);
      n++;
    end while (bus.dcm_reset && n < 20);
    check_eq("pwrup_dcm_len", n, P);
    repeat (10 - n) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    n = 0;
    while (!bus.clk_ok && n < 40) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq("pwrup_run_delay", n, 2 + S);
    check_eq("pwrup_sys_reset_n", int'(bus.sys_reset_n), 1);
    check_eq("pwrup_relock", int'(bus.relock_cnt), 0);
    check_eq("pwrup_timeout", int'(bus.timeout_cnt), 0);

    // Lock loss in RUN: one-cycle drop.
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    n = 0;
    while (bus.sys_reset_n && n < 3) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq("loss_sys_reset_n", int'(bus.sys_reset_n), 0);
    check_eq("loss_state", int'(bus.state), 0);
    check_eq("loss_relock", int'(bus.relock_cnt), 1);
    wait_run(60, "loss_rerun");

    // Glitch in STABLE: locked_s low at STABLE count 5.
    cycle(1'b1, 1'b1);
    wait_model(2, 3, 1'b1, 60, "glitch_reach_stable");
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check_eq("glitch_state", int'(bus.state), 0);
    check_eq("glitch_relock", int'(bus.relock_cnt), 2);
    n = 0;
    while (!bus.clk_ok && n < 40) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq("glitch_run_delay", n, P + 1 + S);

    // Force and lock loss in the same RUN cycle: no relock count.
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_eq("simul_state", int'(bus.state), 0);
    check_eq("simul_relock", int'(bus.relock_cnt), 2);
    // Force on the 3rd RST cycle restarts the full pulse.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    n = 0;
    while (bus.dcm_reset && n < 10) begin
      cycle(1'b1, 1'b0);
      n++;
    end
    check_eq("force_rst_restart", n, P);
    wait_run(60, "force_rerun");

    // Randomized lock activity and forced restarts.
    lkv = 1'b1;
    repeat (1500) begin
      if ($urandom_range(0, 15) == 0) lkv = ~lkv;
      cycle(lkv, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    // Timeout saturation: lock held low through more than 255 retries.
    repeat (260 * (T + P)) cycle(1'b0, 1'b0);
    check_eq("timeout_sat", int'(bus.timeout_cnt), 255);
    wait_run(60, "sat_rerun");

    // Asynchronous reset pulse between clock edges while in RUN.
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_state", int'(bus.state), 0);
    check_eq("async_dcm_reset", int'(bus.dcm_reset), 1);
    check_eq("async_sys_reset_n", int'(bus.sys_reset_n), 0);
    check_eq("async_clk_ok", int'(bus.clk_ok), 0);
    check_eq("async_relock", int'(bus.relock_cnt), 0);
    check_eq("async_timeout", int'(bus.timeout_cnt), 0);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (20) cycle(1'b1, 1'b0);
    check_eq("post_async_run", int'(bus.clk_ok), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_lock_monitor.md
PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 SHALL provide parameter RST_PULSE_CYCLES, default 16, meaning dcm_reset pulse width in clk_in cycles (range 2-255).
REQ-002 SHALL provide parameter LOCK_TIMEOUT, default 4096, meaning maximum WAIT_LOCK cycles before retry (range 4-65535).
REQ-003 SHALL provide parameter STABLE_CYCLES, default 256, meaning consecutive synchronized-locked cycles required before release (range 2-65535).
REQ-004 SHALL have port clk_in  input  1  free-running reference clock (same source as the PLL input); sole clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port locked  input  1  PLL lock status, asynchronous to clk_in.
REQ-007 SHALL have port force_reset  input  1  synchronous single-cycle request to restart the PLL.
REQ-008 SHALL have port dcm_reset  output  1  active-high PLL reset, driven to the PLL RST input.
REQ-009 SHALL have port sys_reset_n  output  1  active-low reset for logic in the PLL output domains.
REQ-010 SHALL have port clk_ok  output  1  high while in RUN.
REQ-011 SHALL have port state  output  2  current FSM state encoding.
REQ-012 SHALL have port relock_cnt  output  8  saturating count of lock losses.
REQ-013 SHALL have port timeout_cnt  output  8  saturating count of WAIT_LOCK timeouts.

Function
REQ-014 SHALL synchronize locked through two clk_in flops (locked_s); all decisions use locked_s only (2-cycle latency).
REQ-015 SHALL implement FSM states RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.
REQ-016 SHALL use a single 16-bit cycle counter, cleared on every state transition.
REQ-017 RST: dcm_reset=1; after exactly RST_PULSE_CYCLES cycles in RST -> WAIT_LOCK.
REQ-018 WAIT_LOCK: dcm_reset=0; locked_s=1 -> STABLE next cycle; locked_s=0 on cycle LOCK_TIMEOUT -> RST and timeout_cnt+1.
REQ-019 STABLE: after STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN; any locked_s=0 -> RST and relock_cnt+1.
REQ-020 RUN: sys_reset_n=1, clk_ok=1; locked_s=0 -> RST and relock_cnt+1.
REQ-021 force_reset=1 in any state SHALL cause transition to RST next cycle without counter increment; it takes priority over all other transitions in the same cycle.
REQ-022 force_reset asserted while already in RST SHALL restart the RST pulse (full RST_PULSE_CYCLES from that point).
REQ-023 sys_reset_n and clk_ok SHALL be registered, rising on the first RUN cycle and falling on the first cycle after leaving RUN; outside RUN they are 0.
REQ-024 dcm_reset SHALL be registered and glitch-free; it is 1 exactly during RST cycles.
REQ-025 relock_cnt and timeout_cnt SHALL saturate at 255 and never wrap; they are cleared only by reset_n.
REQ-026 state output SHALL equal the registered FSM state, with no combinational path from inputs to outputs.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=RST, dcm_reset=1, sys_reset_n=0, clk_ok=0, cycle counter=0, relock_cnt=0, timeout_cnt=0, synchronizer flops=0.
REQ-028 The first RST pulse after reset_n deassertion SHALL last exactly RST_PULSE_CYCLES cycles, counted from the first clk_in edge with reset_n=1.
REQ-029 reset_n assertion mid-operation (any state) SHALL immediately drop sys_reset_n and clk_ok and raise dcm_reset.

Verification (RST_PULSE_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8)
REQ-030 Power-up: release reset_n, locked rises 10 cycles later and stays high -> dcm_reset high for exactly 4 cycles; RUN entered 2+8 cycles after locked; sys_reset_n=1; counters 0.
REQ-031 Timeout: locked held 0 -> after each WAIT_LOCK run of 32 cycles, a 4-cycle dcm_reset pulse follows; timeout_cnt increments once per pulse and saturates at 255 after 255 timeouts.
REQ-032 Lock loss in RUN: locked drops for 1 cycle -> within 3 cycles sys_reset_n=0, state=RST; relock_cnt=1; normal re-lock then returns to RUN.
REQ-033 Glitch in STABLE: locked low for 1 cycle at STABLE count 5 -> RST with relock_cnt+1; no RUN entry before a fresh 8-cycle stable window.
REQ-034 Simultaneous events: force_reset and locked_s fall in the same RUN cycle -> RST, relock_cnt unchanged; force_reset on the 3rd RST cycle -> dcm_reset stays high 4 more cycles.
REQ-035 Async reset mid-RUN: pulse reset_n low between clk_in edges -> outputs reach their reset values before the next edge; counters cleared.
